// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours.
//   fetch_state_e : fetch FSM states (REQ / WAIT / DROP)
//   NOP_INSTR     : addi x0,x0,0, used as the bubble / flush instruction
//   align_word()  : forces bits [1:0] of an address to zero
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,   // ready to issue a fetch
    ST_WAIT = 2'd1,   // one fetch outstanding, response wanted
    ST_DROP = 2'd2    // one fetch outstanding, response to be discarded
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage and its environment.
//   Control from hazard unit / EX : stall, redirect, redirect_target
//   Instruction memory            : imem_req, imem_addr, imem_ready, imem_rvalid, imem_rdata
//   IF/ID register to decode      : instruction_out, pc_out, pc4_out, valid_out
// master = fetch stage view, slave = environment (memory, hazard unit, decode) view.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        valid_out;

  modport master (
    input  stall, redirect, redirect_target,
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instruction_out, pc_out, pc4_out, valid_out
  );

  modport slave (
    output stall, redirect, redirect_target,
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instruction_out, pc_out, pc4_out, valid_out
  );

endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register used when a fetched word
// arrives while decode is stalled.
//   clk      : clock
//   reset    : synchronous, active-low
//   i_load   : capture i_instr / i_pc, mark valid
//   i_unload : entry consumed, mark empty
//   i_clear  : flush (wins over load and unload)
//   o_valid  : entry holds a word
//   o_instr, o_pc : buffered word and its address
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID pipeline register.
// Keeps the PC, issues one word fetch at a time over a req/ready + rvalid
// handshake and presents {instruction, pc, pc+4, valid} registered to decode.
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous, active-low
//   fetch_bus : instruction_fetch_if.master (control in, imem bus, IF/ID outputs)
// Priority each cycle: reset > redirect > stall > normal.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instruction_fetch_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_fetch_if.master   fetch_bus
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;       // next address to fetch
  logic [31:0]  r_req_pc;   // address of the outstanding fetch
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_out;
  logic [31:0]  r_pc4_out;
  logic         r_valid;

  logic         w_skid_valid;
  logic [31:0]  w_skid_instr;
  logic [31:0]  w_skid_pc;
  logic [31:0]  w_target;
  logic         w_req;
  logic         w_accept;
  logic         w_deliver;
  logic         w_skid_load;
  logic         w_skid_unload;

  assign w_target  = align_word(fetch_bus.redirect_target);

  // A full skid buffer blocks new fetches, so at most one word is ever buffered.
  assign w_req     = (r_state == ST_REQ) && !fetch_bus.redirect && !w_skid_valid;
  assign w_accept  = w_req && fetch_bus.imem_ready;

  // Response is only meaningful in WAIT; rvalid in REQ is a protocol error
  // (e.g. a response still in flight across reset) and is ignored.
  assign w_deliver = (r_state == ST_WAIT) && fetch_bus.imem_rvalid && !fetch_bus.redirect;

  assign w_skid_load   = w_deliver && fetch_bus.stall;
  assign w_skid_unload = !fetch_bus.redirect && !fetch_bus.stall && w_skid_valid;

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (fetch_bus.redirect),
    .i_instr  (fetch_bus.imem_rdata),
    .i_pc     (r_req_pc),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );

  // PC register and fetch FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      if (fetch_bus.redirect) begin
        r_pc <= w_target;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end

      case (r_state)
        ST_REQ: begin
          if (w_accept) begin
            r_req_pc <= r_pc;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A redirect with the response still pending must swallow that response.
          if (fetch_bus.redirect) begin
            r_state <= fetch_bus.imem_rvalid ? ST_REQ : ST_DROP;
          end else if (fetch_bus.imem_rvalid) begin
            r_state <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (fetch_bus.imem_rvalid) begin
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  // IF/ID register: flush beats stall; the skid entry is older than any new delivery.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_pc_out  <= 32'h0;
      r_pc4_out <= 32'h0;
    end else if (fetch_bus.redirect) begin
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
    end else if (!fetch_bus.stall) begin
      if (w_skid_valid) begin
        r_valid   <= 1'b1;
        r_instr   <= w_skid_instr;
        r_pc_out  <= w_skid_pc;
        r_pc4_out <= w_skid_pc + 32'd4;
      end else if (w_deliver) begin
        r_valid   <= 1'b1;
        r_instr   <= fetch_bus.imem_rdata;
        r_pc_out  <= r_req_pc;
        r_pc4_out <= r_req_pc + 32'd4;
      end else begin
        r_valid   <= 1'b0;
        r_instr   <= NOP_INSTR;
      end
    end
  end

  assign fetch_bus.imem_req        = w_req;
  assign fetch_bus.imem_addr       = r_pc;
  assign fetch_bus.instruction_out = r_instr;
  assign fetch_bus.pc_out          = r_pc_out;
  assign fetch_bus.pc4_out         = r_pc4_out;
  assign fetch_bus.valid_out       = r_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: random stall/redirect/reset traffic against
// a memory responder, with a queue-based scoreboard of expected deliveries.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if ifc ();

  instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_bus (ifc)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;

  // Reference model: next fetch address and the one live (not flushed) fetch.
  logic [31:0] m_pc = RST_PC;
  bit          m_live = 1'b0;
  logic [31:0] m_live_addr = 32'h0;

  // Memory responder state
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;

  // Stimulus knobs
  int p_ready = 100, p_stall = 0, p_redir = 0, max_lat = 0, p_reset_pm = 0;

  // Controls seen in the previous cycle, for the monitor
  bit prev_have = 1'b0, prev_reset = 1'b0, prev_stall = 1'b0, prev_redirect = 1'b0;
  logic [31:0] s_instr, s_pc, s_pc4;
  logic        s_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h0000_00A5;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(3, 0) == 0)
      return 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
    return $urandom & 32'h0000_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic drive(input bit f_rst, input bit f_redir, input logic [31:0] f_tgt);
    @(posedge clk);
    #1;
    reset               = f_rst ? 1'b0 : !($urandom_range(999, 0) < p_reset_pm);
    ifc.stall           = ($urandom_range(99, 0) < p_stall);
    ifc.redirect        = f_redir || ($urandom_range(99, 0) < p_redir);
    ifc.redirect_target = f_redir ? f_tgt : rand_target();
    ifc.imem_rvalid     = mem_pend && (mem_cnt == 0);
    ifc.imem_rdata      = (mem_pend && (mem_cnt == 0)) ? mem_word(mem_addr) : $urandom;
    ifc.imem_ready      = reset && !mem_pend && ($urandom_range(99, 0) < p_ready);
  endtask

  // Scoreboard push side: observes the cycle's bus activity before the edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        exp_q.delete();
        m_pc   = RST_PC;
        m_live = 1'b0;
      end else begin
        if (ifc.redirect) chk("no_req_on_redirect", 32'(ifc.imem_req), 32'd0);
        if (ifc.imem_rvalid) begin
          if (m_live && !ifc.redirect)
            exp_q.push_back('{instr: mem_word(m_live_addr), pc: m_live_addr, pc4: m_live_addr + 32'd4});
          m_live = 1'b0;
        end
        if (ifc.imem_req && ifc.imem_ready) begin
          chk("fetch_addr", ifc.imem_addr, m_pc);
          m_live_addr = m_pc;
          m_live      = 1'b1;
          m_pc        = m_pc + 32'd4;
        end
        if (ifc.redirect) begin
          exp_q.delete();
          m_pc   = ifc.redirect_target & 32'hFFFF_FFFC;
          m_live = 1'b0;
        end
      end
      // memory side bookkeeping
      if (ifc.imem_rvalid) mem_pend = 1'b0;
      if (reset && ifc.imem_req && ifc.imem_ready) begin
        mem_pend = 1'b1;
        mem_addr = ifc.imem_addr;
        mem_cnt  = $urandom_range(max_lat, 0);
      end else if (mem_pend && mem_cnt > 0) begin
        mem_cnt--;
      end
      prev_reset    = reset;
      prev_stall    = ifc.stall;
      prev_redirect = ifc.redirect;
      prev_have     = 1'b1;
    end
  end

  // Monitor: checks what the last edge did to the IF/ID register.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_have) begin
        if (!prev_reset) begin
          chk("rst_valid", 32'(ifc.valid_out), 32'd0);
          chk("rst_instr", ifc.instruction_out, NOP);
          chk("rst_pc", ifc.pc_out, 32'h0);
          chk("rst_pc4", ifc.pc4_out, 32'h0);
          if (!ifc.redirect) begin
            chk("rst_req", 32'(ifc.imem_req), 32'd1);
            chk("rst_addr", ifc.imem_addr, RST_PC);
          end
        end else if (prev_redirect) begin
          chk("flush_valid", 32'(ifc.valid_out), 32'd0);
          chk("flush_instr", ifc.instruction_out, NOP);
        end else if (prev_stall) begin
          chk("hold_valid", 32'(ifc.valid_out), 32'(s_valid));
          chk("hold_instr", ifc.instruction_out, s_instr);
          chk("hold_pc", ifc.pc_out, s_pc);
          chk("hold_pc4", ifc.pc4_out, s_pc4);
        end else begin
          chk("valid", 32'(ifc.valid_out), 32'(exp_q.size() != 0));
          if (ifc.valid_out === 1'b1 && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            pops++;
            chk("instr", ifc.instruction_out, e.instr);
            chk("pc", ifc.pc_out, e.pc);
            chk("pc4", ifc.pc4_out, e.pc4);
          end else if (ifc.valid_out !== 1'b1) begin
            chk("bubble_instr", ifc.instruction_out, NOP);
          end
        end
      end
      s_valid = ifc.valid_out;
      s_instr = ifc.instruction_out;
      s_pc    = ifc.pc_out;
      s_pc4   = ifc.pc4_out;
    end
  end

  initial begin
    int pops_start;
    reset               = 1'b0;
    ifc.stall           = 1'b0;
    ifc.redirect        = 1'b0;
    ifc.redirect_target = 32'h0;
    ifc.imem_ready      = 1'b0;
    ifc.imem_rvalid     = 1'b0;
    ifc.imem_rdata      = 32'h0;

    // reset held for two cycles
    drive(1'b1, 1'b0, 32'h0);

    // straight-line fetch, ready always, data one cycle after accept
    p_ready = 100; max_lat = 0; p_stall = 0; p_redir = 0; p_reset_pm = 0;
    pops_start = pops;
    for (int i = 0; i < 21; i++) drive(1'b0, 1'b0, 32'h0);
    chk("straight_rate", 32'((pops - pops_start) >= 8), 32'd1);

    // wrap-around: misaligned target near the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFF7);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 32'h0);

    // directed redirect to 0x100
    drive(1'b0, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 32'h0);

    // random traffic with stalls, redirects, variable latency and rare resets
    p_ready = 70; max_lat = 2; p_stall = 25; p_redir = 6; p_reset_pm = 3;
    for (int i = 0; i < 3000; i++) drive(1'b0, 1'b0, 32'h0);

    // drain
    p_ready = 100; max_lat = 0; p_stall = 0; p_redir = 0; p_reset_pm = 0;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    chk("min_deliveries", 32'(pops >= 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
